// File: rtl/inta_sequencer.sv
// inta_sequencer
//   CPU-side interrupt-acknowledge initiator for an 8259A-style PIC. It watches the
//   PIC's INT line, which is gated by the CPU interrupt-enable flag. It then issues the
//   two-pulse INTA sequence, captures the vector driven on DATA_IN during the second
//   pulse, and offers that vector to the core over a valid/ready handshake.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   INT        in   1      PIC interrupt request (asynchronous, synchronised here)
//   IF_EN      in   1      CPU interrupt-enable; 0 blocks new sequences
//   DATA_IN    in   VEC_W  PIC data bus, sampled in the last ACK2 cycle
//   VEC_READY  in   1      core accepts VEC_OUT
//   INTA       out  1      interrupt acknowledge, active low
//   VEC_OUT    out  VEC_W  captured vector
//   VEC_VALID  out  1      VEC_OUT holds an unconsumed vector
//   BUSY       out  1      FSM not in IDLE
module inta_sequencer #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2,
    parameter int VEC_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             INT,
    input  logic             IF_EN,
    input  logic [VEC_W-1:0] DATA_IN,
    input  logic             VEC_READY,
    output logic             INTA,
    output logic [VEC_W-1:0] VEC_OUT,
    output logic             VEC_VALID,
    output logic             BUSY
);

    localparam int MAXC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES
                                                              : INTA_GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LOW_LD = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(INTA_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK1,
        S_GAP1,
        S_ACK2,
        S_HOLD,
        S_RECOV
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             int_meta_q, int_s_q;
    logic             inta_q, valid_q, busy_q;

    // Two-flop synchroniser; only int_s_q is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_s_q    <= int_meta_q;
        end
    end

    // Each timed state is entered with cnt = N-1 and exits on the cycle where
    // cnt == 0, so it lasts exactly N cycles. The counter never decrements past 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        case (state_q)
            S_IDLE: begin
                if (int_s_q && IF_EN) begin
                    state_d = S_ACK1;
                    cnt_d   = LOW_LD;
                end
            end
            S_ACK1: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP1;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP1: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK2;
                    cnt_d   = LOW_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK2: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    vec_d   = DATA_IN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (VEC_READY) begin
                    state_d = S_RECOV;
                    cnt_d   = GAP_LD;
                end
            end
            S_RECOV: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The outputs are registered copies decoded from the next state. As a result
    // they change on the same edge as the state and never follow an input
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            inta_q  <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            inta_q  <= !((state_d == S_ACK1) || (state_d == S_ACK2));
            valid_q <= (state_d == S_HOLD);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign INTA      = inta_q;
    assign VEC_OUT   = vec_q;
    assign VEC_VALID = valid_q;
    assign BUSY      = busy_q;

endmodule
